// File: rtl/ntt_radix8_pipe_if.sv
// Handshake and data bundle for the radix-8 NTT butterfly core.
// The core uses the slave modport; the feeding and draining logic uses master.
interface ntt_radix8_pipe_if #(
   parameter int WIDTH = 18
);
   logic               in_valid;
   logic               in_ready;
   logic               in_mode;
   logic [8*WIDTH-1:0] in_data;
   logic [8*WIDTH-1:0] in_psi;
   logic [4*WIDTH-1:0] in_w;
   logic               out_valid;
   logic               out_ready;
   logic [8*WIDTH-1:0] out_data;
   logic               out_err;

   modport master (
      output in_valid, in_mode, in_data, in_psi, in_w, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_mode, in_data, in_psi, in_w, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/ntt_radix8_pipe.sv
// Four-stage pipelined radix-8 NTT butterfly with mod-Q reduction and optional
// inverse scaling. Each stage holds one beat; a stage refills whenever its beat moves on.
module ntt_radix8_pipe #(
   parameter int WIDTH = 18,
   parameter int Q     = 12289,
   parameter int N_INV = 10753
) (
   input logic              clk,
   input logic              rst,
   ntt_radix8_pipe_if.slave bus
);
   typedef logic [WIDTH-1:0]   coef_t;
   typedef logic [WIDTH:0]     sum_t;
   typedef logic [2*WIDTH-1:0] prod_t;

   localparam coef_t QW     = coef_t'(Q);
   localparam coef_t NINV_W = coef_t'(N_INV);
   localparam sum_t  QE     = sum_t'(Q);
   localparam prod_t QP     = prod_t'(Q);

   // Operands of add/sub are always already reduced, so one conditional subtract suffices.
   function automatic coef_t mod_add(input coef_t a, input coef_t b);
      sum_t s;
      s = sum_t'(a) + sum_t'(b);
      if (s >= QE) s = s - QE;
      return coef_t'(s);
   endfunction

   function automatic coef_t mod_sub(input coef_t a, input coef_t b);
      sum_t d;
      d = sum_t'(a) + QE - sum_t'(b);
      if (d >= QE) d = d - QE;
      return coef_t'(d);
   endfunction

   function automatic coef_t mod_mul(input coef_t a, input coef_t b);
      prod_t p;
      p = prod_t'(a) * prod_t'(b);
      return coef_t'(p % QP);
   endfunction

   logic  v1, v2, v3, v4;
   logic  adv1, adv2, adv3, adv4;
   logic  ld1, ld2, ld3, ld4;
   logic  accept;

   coef_t p    [8];
   coef_t w_in [4];
   coef_t s1_d [8];
   coef_t s2_d [8];
   coef_t s3_d [8];
   coef_t s4_d [8];
   coef_t t2   [4];
   coef_t t3   [4];
   logic  err1_d;

   coef_t s1_q [8];
   coef_t s2_q [8];
   coef_t s3_q [8];
   coef_t s4_q [8];
   coef_t w1_q [4];
   coef_t w2_q [4];
   logic  mode1_q, mode2_q, mode3_q;
   logic  err1_q, err2_q, err3_q, err4_q;
   logic [8*WIDTH-1:0] out_data_w;

   // Backpressure ripples from the output back to in_ready within one cycle.
   assign adv4   = v4 && bus.out_ready;
   assign ld4    = !v4 || adv4;
   assign adv3   = v3 && ld4;
   assign ld3    = !v3 || adv3;
   assign adv2   = v2 && ld3;
   assign ld2    = !v2 || adv2;
   assign adv1   = v1 && ld2;
   assign ld1    = !v1 || adv1;
   assign accept = bus.in_valid && ld1;

   assign bus.in_ready  = ld1;
   assign bus.out_valid = v4;
   assign bus.out_err   = err4_q;
   assign bus.out_data  = out_data_w;

   always_comb begin
      err1_d = 1'b0;
      for (int i = 0; i < 8; i++) begin
         p[i] = mod_mul(bus.in_data[i*WIDTH +: WIDTH], bus.in_psi[i*WIDTH +: WIDTH]);
         if ((bus.in_data[i*WIDTH +: WIDTH] >= QW) || (bus.in_psi[i*WIDTH +: WIDTH] >= QW))
            err1_d = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         w_in[i]       = bus.in_w[i*WIDTH +: WIDTH];
         s1_d[2*i]     = mod_add(p[2*i], p[2*i+1]);
         s1_d[2*i+1]   = mod_sub(p[2*i], p[2*i+1]);
      end
   end

   // Stage 2 pairs (0,2),(1,3),(4,6),(5,7) with twiddles w0,w2,w0,w2.
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         t2[j]       = mod_mul(s1_q[(j/2)*4 + (j%2) + 2], w1_q[(j%2)*2]);
         s2_d[2*j]   = mod_add(s1_q[(j/2)*4 + (j%2)], t2[j]);
         s2_d[2*j+1] = mod_sub(s1_q[(j/2)*4 + (j%2)], t2[j]);
      end
   end

   // Stage 3 pairs (j, j+4) with twiddle wj; stage 4 optionally scales by N_INV.
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         t3[j]       = mod_mul(s2_q[j+4], w2_q[j]);
         s3_d[2*j]   = mod_add(s2_q[j], t3[j]);
         s3_d[2*j+1] = mod_sub(s2_q[j], t3[j]);
      end
      for (int i = 0; i < 8; i++) begin
         s4_d[i] = mode3_q ? mod_mul(s3_q[i], NINV_W) : s3_q[i];
      end
   end

   always_comb begin
      out_data_w = '0;
      for (int i = 0; i < 8; i++) begin
         out_data_w[i*WIDTH +: WIDTH] = s4_q[i];
      end
   end

   // Data registers only capture when a real beat moves in, so a stalled output holds still.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         v4      <= 1'b0;
         mode1_q <= 1'b0;
         mode2_q <= 1'b0;
         mode3_q <= 1'b0;
         err1_q  <= 1'b0;
         err2_q  <= 1'b0;
         err3_q  <= 1'b0;
         err4_q  <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            s1_q[i] <= '0;
            s2_q[i] <= '0;
            s3_q[i] <= '0;
            s4_q[i] <= '0;
         end
         for (int i = 0; i < 4; i++) begin
            w1_q[i] <= '0;
            w2_q[i] <= '0;
         end
      end else begin
         if (ld1) v1 <= bus.in_valid;
         if (ld2) v2 <= v1;
         if (ld3) v3 <= v2;
         if (ld4) v4 <= v3;
         if (accept) begin
            s1_q    <= s1_d;
            w1_q    <= w_in;
            mode1_q <= bus.in_mode;
            err1_q  <= err1_d;
         end
         if (ld2 && v1) begin
            s2_q    <= s2_d;
            w2_q    <= w1_q;
            mode2_q <= mode1_q;
            err2_q  <= err1_q;
         end
         if (ld3 && v2) begin
            s3_q    <= s3_d;
            mode3_q <= mode2_q;
            err3_q  <= err2_q;
         end
         if (ld4 && v3) begin
            s4_q    <= s4_d;
            err4_q  <= err3_q;
         end
      end
   end
endmodule
